// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared March C- element table, FSM states and constants for the SRAM BIST
package sram_bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
  localparam int OPS_PER_ADDR_TOTAL = 10;
  localparam logic [5:0] ELEM_DOWN = 6'b011000;
  localparam logic [5:0] ELEM_TWO  = 6'b011110;
  localparam logic [5:0] ELEM_RVAL = 6'b010100;
  localparam logic [5:0] ELEM_WVAL = 6'b001010;
endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp: read-latency-matched compare pipe with fail flag, first-failure capture and saturating count
module sram_bist_cmp
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  exp_bit,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            elem,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            fail_count
);
  logic [READ_LATENCY-1:0] v_q, v_d, x_q, x_d;
  logic [ADDR_WIDTH-1:0]   a_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0]   a_d [READ_LATENCY];
  logic [2:0]              el_q [READ_LATENCY];
  logic [2:0]              el_d [READ_LATENCY];
  logic                    fail_q, fail_d, miss;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [7:0]              fail_count_q, fail_count_d;

  // Shift read tags alongside the SRAM latency and score the entry leaving the pipe
  always_comb begin
    v_d = v_q;
    x_d = x_q;
    a_d = a_q;
    el_d = el_q;
    for (int i = READ_LATENCY - 1; i > 0; i--) begin
      v_d[i] = v_q[i-1];
      x_d[i] = x_q[i-1];
      a_d[i] = a_q[i-1];
      el_d[i] = el_q[i-1];
    end
    v_d[0] = push;
    x_d[0] = exp_bit;
    a_d[0] = addr;
    el_d[0] = elem;
    miss = v_q[READ_LATENCY-1] && (dout0 != {DATA_WIDTH{x_q[READ_LATENCY-1]}});
    fail_d = clr ? 1'b0 : (fail_q | miss);
    fail_addr_d = clr ? '0 : (miss && !fail_q) ? a_q[READ_LATENCY-1] : fail_addr_q;
    fail_elem_d = clr ? '0 : (miss && !fail_q) ? el_q[READ_LATENCY-1] : fail_elem_q;
    fail_count_d = clr ? '0 : (miss && fail_count_q != 8'hff) ? fail_count_q + 8'd1 : fail_count_q;
  end

  // Pipe and result registers; reset flushes in-flight reads
  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      v_q <= '0;
      x_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        a_q[i] <= '0;
        el_q[i] <= '0;
      end
      fail_q <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      fail_count_q <= '0;
    end else begin
      v_q <= v_d;
      x_q <= x_d;
      a_q <= a_d;
      el_q <= el_d;
      fail_q <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign fail = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
  assign fail_count = fail_count_q;
endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST controller owning the SRAM port, transparent to the functional port when idle
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 7,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic [7:0]            fail_count,
  input  logic                  func_csb0,
  input  logic                  func_web0,
  input  logic [ADDR_WIDTH-1:0] func_addr0,
  input  logic [DATA_WIDTH-1:0] func_din0,
  output logic [DATA_WIDTH-1:0] func_dout0,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);
  localparam int DW = $clog2(READ_LATENCY + 1);
  state_e                state_q, state_d;
  elem_e                 elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  op_q, op_d, csb_q, csb_d, web_q, web_d, last_addr, accept, idle;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [DW-1:0]         drain_q, drain_d;

  // Walk elements/addresses/ops and precompute the next cycle's registered SRAM command
  always_comb begin
    state_d = state_q;
    elem_d = elem_q;
    addr_d = addr_q;
    op_d = op_q;
    drain_d = drain_q;
    idle = (state_q == IDLE) || (state_q == DONE);
    accept = idle && start;
    last_addr = ELEM_DOWN[elem_q] ? (addr_q == '0) : (addr_q == '1);
    if (accept) begin
      state_d = RUN;
      elem_d = E0;
      addr_d = '0;
      op_d = 1'b0;
    end else if (state_q == RUN) begin
      if (ELEM_TWO[elem_q] && !op_q) op_d = 1'b1;
      else begin
        op_d = 1'b0;
        if (!last_addr) addr_d = ELEM_DOWN[elem_q] ? addr_q - 1'b1 : addr_q + 1'b1;
        else if (elem_q == E5) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          elem_d = elem_e'(elem_q + 3'd1);
          addr_d = ELEM_DOWN[elem_d] ? '1 : '0;
        end
      end
    end else if (state_q == DRAIN) begin
      if (drain_q == DW'(READ_LATENCY - 1)) state_d = DONE;
      else drain_d = drain_q + 1'b1;
    end
    csb_d = state_d != RUN;
    web_d = !((elem_d == E0) || (ELEM_TWO[elem_d] && op_d));
    din_d = {DATA_WIDTH{ELEM_WVAL[elem_d]}};
  end

  // FSM and registered BIST command; reset aborts any test
  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      state_q <= IDLE;
      elem_q <= E0;
      addr_q <= '0;
      op_q <= 1'b0;
      drain_q <= '0;
      csb_q <= 1'b1;
      web_q <= 1'b1;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      addr_q <= addr_d;
      op_q <= op_d;
      drain_q <= drain_d;
      csb_q <= csb_d;
      web_q <= web_d;
      din_q <= din_d;
    end
  end

  sram_bist_cmp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_cmp (
    .clk0(clk0),
    .rst0_n(rst0_n),
    .clr(accept),
    .push((state_q == RUN) && web_q),
    .exp_bit(ELEM_RVAL[elem_q]),
    .addr(addr_q),
    .elem(elem_q),
    .dout0(dout0),
    .fail(fail),
    .fail_addr(fail_addr),
    .fail_elem(fail_elem),
    .fail_count(fail_count)
  );

  assign busy = (state_q == RUN) || (state_q == DRAIN);
  assign done = state_q == DONE;
  assign csb0 = busy ? csb_q : func_csb0;
  assign web0 = busy ? web_q : func_web0;
  assign addr0 = busy ? addr_q : func_addr0;
  assign din0 = busy ? din_q : func_din0;
  assign func_dout0 = dout0;
endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test controller that sits directly upstream of the 32x128 single-port SRAM macro and owns its port: it runs a March C- sequence over every address, checks every read against the expected background, and reports pass/fail with first-failure diagnostics. When idle it is transparent and passes the functional port through to the SRAM unchanged. This gives silicon and simulation a deterministic check that catches stuck-at, coupling and write-corruption faults, including malicious write suppression.

## Interface
- DATA_WIDTH, 32, SRAM word width
- ADDR_WIDTH, 7, SRAM address width; depth N = 2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from read issue edge to valid dout0
- clk0  in  1  clock, all logic on rising edge
- rst0_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; starts a test when idle
- busy  out  1  test in progress
- done  out  1  test complete; held until next accepted start or reset
- fail  out  1  at least one read mismatch; valid when done=1
- fail_addr  out  ADDR_WIDTH  address of first mismatch
- fail_elem  out  3  March element index (0-5) of first mismatch
- fail_count  out  8  mismatching reads, saturates at 255
- func_csb0, func_web0  in  1 each  functional chip select / write enable (active low)
- func_addr0  in  ADDR_WIDTH  functional address
- func_din0  in  DATA_WIDTH  functional write data
- func_dout0  out  DATA_WIDTH  equals dout0 at all times
- csb0, web0  out  1 each  to SRAM
- addr0  out  ADDR_WIDTH  to SRAM
- din0  out  DATA_WIDTH  to SRAM
- dout0  in  DATA_WIDTH  from SRAM

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE: SRAM port mirrors func_* combinationally. start=1 -> RUN, and done, fail, fail_addr, fail_elem and fail_count clear. start while busy is ignored.
- RUN: element sequence, with 0 = all-zeros word and 1 = all-ones word:
  - e0 up (w0)
  - e1 up (r0, w1)
  - e2 up (r1, w0)
  - e3 down (r0, w1)
  - e4 down (r1, w0)
  - e5 up (r0)
- One SRAM operation per cycle, csb0=0 throughout RUN. Total 10N = 1280 operations.
- Up elements: address 0 to N-1. Down elements: N-1 to 0.
- Within a two-op element, the read precedes the write at the same address in consecutive cycles.
- Address counter wraps on element change, with no idle cycle between elements.
- Each read pushes {expected, addr, elem} into a READ_LATENCY-deep compare pipe. On pipe exit, dout0 != expected increments fail_count. The first mismatch sets fail and latches fail_addr and fail_elem, which are never overwritten.
- After the last e5 read -> DRAIN for READ_LATENCY cycles, csb0=1, then DONE: done=1, busy=0.
- Reset at any time: state IDLE, compare pipe flushed, test aborted, memory contents undefined.

## Timing
- Reset values: busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_count=0. SRAM port follows func_* because the block is in IDLE.
- Start sampled at edge k -> busy=1 from cycle k+1. The first op (w0 at address 0) is driven during cycle k+1. The last op is driven in cycle k+1280.
- done=1 and busy=0 from cycle k+1281+READ_LATENCY.
- Registered outputs during RUN: csb0, web0, addr0 and din0 change only on clk0 edges.
- fail_count saturates at 255 with no wrap.

## Structure
- Package sram_bist_pkg holds:
  - element enum E0..E5
  - per-element constants: direction, op count, read value, write value
  - state enum
  - OPS_PER_ADDR_TOTAL = 10
- Sub-module sram_bist_cmp implements the parameterised compare pipe and the fail/count/first-failure capture.
- Top level holds the FSM, address/op counters and port mux.

## Test plan
- Fault-free SRAM model, start pulse -> done at cycle start+1282, fail=0, fail_count=0, 1280 SRAM ops observed.
- Address 10 bit 3 stuck-at-1 -> fail=1, fail_addr=10, fail_elem=1, fail_count=3.
- Model that silently drops writes after 4 consecutive web0-high cycles, then a BIST run -> fail=1, fail_count>0; separately, a functional write of 0xFACECAFE then read at address 10 while idle returns 0xFACECAFE through func_dout0.
- rst0_n low for 1 cycle at op 500 -> next cycle busy=0, done=0, fail_count=0, SRAM follows func_*; a restart then completes normally.
- start asserted again at op 100 -> ignored, completion cycle unchanged.
- Every address stuck-at-0 in all bits -> fail_count=255 (saturated), fail_addr=0, fail_elem=2.
